// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for serial_subtractor
// Signals: start/a/b/bin (requester -> engine), ready/busy/done/diff/bout (engine -> requester),
//          ovf/zero present only when SUB_FLAGS_EN is defined.
// Modports: master (requester side), slave (engine side).
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_FLAGS_EN
    logic             ovf;
    logic             zero;

    modport master (output start, a, b, bin,
                    input  ready, busy, done, diff, bout, ovf, zero);
    modport slave  (input  start, a, b, bin,
                    output ready, busy, done, diff, bout, ovf, zero);
`else
    modport master (output start, a, b, bin,
                    input  ready, busy, done, diff, bout);
    modport slave  (input  start, a, b, bin,
                    output ready, busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle a - b - bin engine, STEP bits per clock, LSB slice first
// Ports: clk, rst_n (synchronous active-low), bus (serial_subtractor_if.slave):
//        start/a/b/bin request, ready/busy/done handshake, diff/bout result.
// Optional: SUB_FLAGS_EN adds registered signed-overflow (ovf) and zero flags.
// Parameters: WIDTH operand width, STEP bits per clock (WIDTH % STEP must be 0).
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH % STEP != 0) begin : g_bad_step
        $error("serial_subtractor: WIDTH must be a multiple of STEP");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;      // bit position of the current slice
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             done_q;
    logic             ready_q;
    logic             busy_q;

    // One slice of subtraction; the extra MSB of the result is the borrow out of the slice.
    logic [STEP:0]    sub;
    logic [WIDTH-1:0] diff_next;
    logic             last;

    always_comb begin
        sub       = {1'b0, a_r[idx +: STEP]} - {1'b0, b_r[idx +: STEP]} - {{STEP{1'b0}}, brw};
        diff_next = diff_q;
        diff_next[idx +: STEP] = sub[STEP-1:0];
        last      = (cnt == CW'(N - 1));
    end

`ifdef SUB_FLAGS_EN
    logic ovf_q;
    logic zero_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`endif

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SUB_FLAGS_EN
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // DONE with start held is a back-to-back accept, no idle cycle.
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        brw     <= bus.bin;
                        cnt     <= '0;
                        idx     <= '0;
                        diff_q  <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    diff_q <= diff_next;
                    brw    <= sub[STEP];
                    if (last) begin
                        bout_q  <= sub[STEP];
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= DONE;
`ifdef SUB_FLAGS_EN
                        ovf_q   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                   (diff_next[WIDTH-1] != a_r[WIDTH-1]);
                        zero_q  <= (diff_next == '0);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                        idx <= idx + IW'(STEP);
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
